// File: rtl/vram_wr_arb.sv
// VRAM write-port arbiter: routes requester A/B pixel writes to even/odd banks with per-bank round robin.
// Optional fill sequencer built when VRAM_WR_ARB_CLEAR_EN is defined.
module vram_wr_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W:0]   a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              vram_even_we,
    output logic [ADDR_W-1:0] vram_even_addr,
    output logic [DATA_W-1:0] vram_even_d,
    output logic              vram_odd_we,
    output logic [ADDR_W-1:0] vram_odd_addr,
    output logic [DATA_W-1:0] vram_odd_d,
    output logic [15:0]       stall_count
);

    logic              w_idle;
    logic              w_clr_wr;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;

    // rr bit per bank: 0 = A has priority, 1 = B has priority
    logic [1:0] r_rr;
    logic [1:0] w_ca;
    logic [1:0] w_cb;
    logic [1:0] w_ga;
    logic [1:0] w_gb;
    logic       w_stall;

    logic              w_even_we_nxt;
    logic [ADDR_W-1:0] w_even_addr_nxt;
    logic [DATA_W-1:0] w_even_d_nxt;
    logic              w_odd_we_nxt;
    logic [ADDR_W-1:0] w_odd_addr_nxt;
    logic [DATA_W-1:0] w_odd_d_nxt;

    // Pick {we, addr, d} for one bank: grants first (never coexist with clear), then clear, else hold.
    function automatic logic [ADDR_W+DATA_W:0] bank_next(
        input logic              ga,
        input logic              gb,
        input logic              clr,
        input logic [ADDR_W-1:0] aa,
        input logic [DATA_W-1:0] ad,
        input logic [ADDR_W-1:0] ba,
        input logic [DATA_W-1:0] bd,
        input logic [ADDR_W-1:0] ca,
        input logic [DATA_W-1:0] cd,
        input logic [ADDR_W-1:0] ha,
        input logic [DATA_W-1:0] hd
    );
        logic [ADDR_W+DATA_W:0] res;
        if (ga) begin
            res = {1'b1, aa, ad};
        end else if (gb) begin
            res = {1'b1, ba, bd};
        end else if (clr) begin
            res = {1'b1, ca, cd};
        end else begin
            res = {1'b0, ha, hd};
        end
        return res;
    endfunction

`ifdef VRAM_WR_ARB_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_clr_val;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; termination on the all-ones counter value
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fill value capture and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
            r_clr_val <= '0;
        end else if ((r_state == ST_IDLE) && clear_start) begin
            r_clr_cnt <= '0;
            r_clr_val <= clear_value;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign w_clr_wr   = (r_state == ST_CLEAR);
    assign w_clr_addr = r_clr_cnt;
    assign w_clr_data = r_clr_val;
    assign clear_busy = ~w_idle;
`else
    logic w_unused_clear;

    assign w_unused_clear = ^{clear_start, clear_value};
    assign w_idle         = 1'b1;
    assign w_clr_wr       = 1'b0;
    assign w_clr_addr     = '0;
    assign w_clr_data     = '0;
    assign clear_busy     = 1'b0;
`endif

    assign w_ca = {a_valid & w_idle & a_addr[0], a_valid & w_idle & ~a_addr[0]};
    assign w_cb = {b_valid & w_idle & b_addr[0], b_valid & w_idle & ~b_addr[0]};
    assign w_ga = w_ca & (~w_cb | ~r_rr);
    assign w_gb = w_cb & (~w_ca | r_rr);

    assign a_ready = |w_ga;
    assign b_ready = |w_gb;
    assign w_stall = w_idle & ((a_valid & ~a_ready) | (b_valid & ~b_ready));

    assign {w_even_we_nxt, w_even_addr_nxt, w_even_d_nxt} = bank_next(
        w_ga[0], w_gb[0], w_clr_wr,
        a_addr[ADDR_W:1], a_data, b_addr[ADDR_W:1], b_data,
        w_clr_addr, w_clr_data, vram_even_addr, vram_even_d);

    assign {w_odd_we_nxt, w_odd_addr_nxt, w_odd_d_nxt} = bank_next(
        w_ga[1], w_gb[1], w_clr_wr,
        a_addr[ADDR_W:1], a_data, b_addr[ADDR_W:1], b_data,
        w_clr_addr, w_clr_data, vram_odd_addr, vram_odd_d);

    // Round-robin pointers: after a grant, favour the other requester in that bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 2'b00;
        end else begin
            r_rr <= (r_rr | w_ga) & ~w_gb;
        end
    end

    // Registered bank write ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_even_we   <= 1'b0;
            vram_even_addr <= '0;
            vram_even_d    <= '0;
            vram_odd_we    <= 1'b0;
            vram_odd_addr  <= '0;
            vram_odd_d     <= '0;
        end else begin
            vram_even_we   <= w_even_we_nxt;
            vram_even_addr <= w_even_addr_nxt;
            vram_even_d    <= w_even_d_nxt;
            vram_odd_we    <= w_odd_we_nxt;
            vram_odd_addr  <= w_odd_addr_nxt;
            vram_odd_d     <= w_odd_d_nxt;
        end
    end

    // Saturating contention counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (w_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Directed bench for vram_wr_arb; clear-sequencer checks follow VRAM_WR_ARB_CLEAR_EN.
module tb_vram_wr_arb;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid, a_ready, b_ready;
    logic [ADDR_W:0]   a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              clear_start, clear_busy;
    logic [DATA_W-1:0] clear_value;
    logic              vram_even_we, vram_odd_we;
    logic [ADDR_W-1:0] vram_even_addr, vram_odd_addr;
    logic [DATA_W-1:0] vram_even_d, vram_odd_d;
    logic [15:0]       stall_count;

    int n_vec = 0;
    int n_err = 0;

    vram_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
        .vram_even_we(vram_even_we), .vram_even_addr(vram_even_addr), .vram_even_d(vram_even_d),
        .vram_odd_we(vram_odd_we), .vram_odd_addr(vram_odd_addr), .vram_odd_d(vram_odd_d),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [ADDR_W:0]   ea, eb;
        logic [DATA_W-1:0] da, db;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_d;
        logic              a_turn;
        int good, busy_n, rdy_viol;

        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        clear_start = 1'b0; clear_value = '0;
        good = 0; busy_n = 0; rdy_viol = 0;

        repeat (2) @(negedge clk);
        check_eq("rst_even_we", {31'd0, vram_even_we}, 32'd0);
        check_eq("rst_odd_we", {31'd0, vram_odd_we}, 32'd0);
        check_eq("rst_even_addr", {22'd0, vram_even_addr}, 32'd0);
        check_eq("rst_odd_d", {24'd0, vram_odd_d}, 32'd0);
        check_eq("rst_busy", {31'd0, clear_busy}, 32'd0);
        check_eq("rst_stall", {16'd0, stall_count}, 32'd0);
        rst_n = 1'b1;

        // single A write to odd bank
        @(negedge clk);
        a_valid = 1'b1; a_addr = 11'h003; a_data = 8'h5A;
        #1;
        check_eq("t1_a_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("t1_odd_we", {31'd0, vram_odd_we}, 32'd1);
        check_eq("t1_odd_addr", {22'd0, vram_odd_addr}, 32'h001);
        check_eq("t1_odd_d", {24'd0, vram_odd_d}, 32'h5A);
        check_eq("t1_even_we", {31'd0, vram_even_we}, 32'd0);

        // A and B to different banks in one cycle
        a_valid = 1'b1; a_addr = 11'h004; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 11'h007; b_data = 8'h22;
        #1;
        check_eq("t2_a_ready", {31'd0, a_ready}, 32'd1);
        check_eq("t2_b_ready", {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("t2_even_we", {31'd0, vram_even_we}, 32'd1);
        check_eq("t2_even_addr", {22'd0, vram_even_addr}, 32'h002);
        check_eq("t2_even_d", {24'd0, vram_even_d}, 32'h11);
        check_eq("t2_odd_we", {31'd0, vram_odd_we}, 32'd1);
        check_eq("t2_odd_addr", {22'd0, vram_odd_addr}, 32'h003);
        check_eq("t2_odd_d", {24'd0, vram_odd_d}, 32'h22);

        // idle cycle: we drops, address/data hold
        @(negedge clk);
        check_eq("hold_even_we", {31'd0, vram_even_we}, 32'd0);
        check_eq("hold_even_addr", {22'd0, vram_even_addr}, 32'h002);
        check_eq("hold_odd_d", {24'd0, vram_odd_d}, 32'h22);
        check_eq("stall_zero", {16'd0, stall_count}, 32'd0);

        // contention on even bank after reset: A, B, A, B
        do_reset();
        ea = 11'h010; da = 8'hA0;
        eb = 11'h020; db = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_addr = ea; a_data = da;
            b_valid = 1'b1; b_addr = eb; b_data = db;
            a_turn = ((i % 2) == 0);
            #1;
            check_eq("rr_a_ready", {31'd0, a_ready}, {31'd0, a_turn});
            check_eq("rr_b_ready", {31'd0, b_ready}, {31'd0, ~a_turn});
            exp_addr = a_turn ? ea[ADDR_W:1] : eb[ADDR_W:1];
            exp_d    = a_turn ? da : db;
            @(negedge clk);
            check_eq("rr_even_we", {31'd0, vram_even_we}, 32'd1);
            check_eq("rr_even_addr", {22'd0, vram_even_addr}, {22'd0, exp_addr});
            check_eq("rr_even_d", {24'd0, vram_even_d}, {24'd0, exp_d});
            if (a_turn) begin
                ea = ea + 11'd2; da = da + 8'd1;
            end else begin
                eb = eb + 11'd2; db = db + 8'd1;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("rr_stall_count", {16'd0, stall_count}, 32'd4);

`ifdef VRAM_WR_ARB_CLEAR_EN
        // clear with a simultaneous request, then a request pending through the clear
        clear_start = 1'b1; clear_value = 8'hFF;
        a_valid = 1'b1; a_addr = 11'h005; a_data = 8'h33;
        #1;
        check_eq("clr_same_cycle_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        clear_start = 1'b0;
        a_addr = 11'h006; a_data = 8'h44;
        check_eq("clr_pre_odd_we", {31'd0, vram_odd_we}, 32'd1);
        check_eq("clr_pre_odd_addr", {22'd0, vram_odd_addr}, 32'h002);
        check_eq("clr_pre_odd_d", {24'd0, vram_odd_d}, 32'h33);
        check_eq("clr_pre_even_we", {31'd0, vram_even_we}, 32'd0);
        check_eq("clr_busy_rise", {31'd0, clear_busy}, 32'd1);
        #1;
        check_eq("clr_ready_low", {31'd0, a_ready}, 32'd0);
        busy_n = 1;
        for (int c = 2; c <= 1025; c++) begin
            @(negedge clk);
            if (vram_even_we && vram_odd_we &&
                (int'(vram_even_addr) == c - 2) && (int'(vram_odd_addr) == c - 2) &&
                (vram_even_d == 8'hFF) && (vram_odd_d == 8'hFF)) begin
                good++;
            end
            if (clear_busy) begin
                busy_n++;
            end
            clear_start = (c == 500) || (c == 1025);
            clear_value = (c == 500) ? 8'h00 : 8'hFF;
            #1;
            if (a_ready) begin
                rdy_viol++;
            end
        end
        check_eq("clr_write_cycles", good, 32'd1024);
        check_eq("clr_busy_cycles", busy_n, 32'd1025);
        check_eq("clr_ready_during", rdy_viol, 32'd0);
        @(negedge clk);
        clear_start = 1'b0;
        check_eq("clr_busy_fall", {31'd0, clear_busy}, 32'd0);
        check_eq("clr_done_no_we", {31'd0, vram_even_we}, 32'd0);
        check_eq("clr_last_addr", {22'd0, vram_even_addr}, 32'h3FF);
        #1;
        check_eq("clr_after_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("clr_after_we", {31'd0, vram_even_we}, 32'd1);
        check_eq("clr_after_addr", {22'd0, vram_even_addr}, 32'h003);
        check_eq("clr_after_d", {24'd0, vram_even_d}, 32'h44);

        // reset during a clear at counter 0x100
        clear_start = 1'b1; clear_value = 8'h77;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            clear_start = 1'b0;
        end
        check_eq("mid_clr_addr", {22'd0, vram_even_addr}, 32'h0FF);
        check_eq("mid_clr_d", {24'd0, vram_even_d}, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_even_we", {31'd0, vram_even_we}, 32'd0);
        check_eq("arst_odd_we", {31'd0, vram_odd_we}, 32'd0);
        check_eq("arst_busy", {31'd0, clear_busy}, 32'd0);
        check_eq("arst_stall", {16'd0, stall_count}, 32'd0);
        check_eq("arst_addr", {22'd0, vram_even_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b1; a_addr = 11'h008; a_data = 8'h12;
        b_valid = 1'b1; b_addr = 11'h00A; b_data = 8'h34;
        #1;
        check_eq("arst_a_first", {31'd0, a_ready}, 32'd1);
        check_eq("arst_b_wait", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        a_valid = 1'b0;
        check_eq("arst_a_addr", {22'd0, vram_even_addr}, 32'h004);
        check_eq("arst_a_d", {24'd0, vram_even_d}, 32'h12);
        #1;
        check_eq("arst_b_ready", {31'd0, b_ready}, 32'd1);
        @(negedge clk);
        b_valid = 1'b0;
        check_eq("arst_b_addr", {22'd0, vram_even_addr}, 32'h005);
        check_eq("arst_b_d", {24'd0, vram_even_d}, 32'h34);
`else
        // clear_start has no effect when the sequencer is not built
        clear_start = 1'b1; clear_value = 8'h99;
        a_valid = 1'b1; a_addr = 11'h00C; a_data = 8'h55;
        #1;
        check_eq("noclr_a_ready", {31'd0, a_ready}, 32'd1);
        check_eq("noclr_busy0", {31'd0, clear_busy}, 32'd0);
        @(negedge clk);
        clear_start = 1'b0; a_valid = 1'b0;
        check_eq("noclr_busy1", {31'd0, clear_busy}, 32'd0);
        check_eq("noclr_even_we", {31'd0, vram_even_we}, 32'd1);
        check_eq("noclr_even_addr", {22'd0, vram_even_addr}, 32'h006);
        check_eq("noclr_even_d", {24'd0, vram_even_d}, 32'h55);
        check_eq("noclr_odd_we", {31'd0, vram_odd_we}, 32'd0);
        @(negedge clk);
        check_eq("noclr_even_we2", {31'd0, vram_even_we}, 32'd0);
        check_eq("noclr_odd_we2", {31'd0, vram_odd_we}, 32'd0);
        check_eq("noclr_busy2", {31'd0, clear_busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_wr_arb.md
# vram_wr_arb

VRAM write-port arbiter and clear sequencer, sitting between pixel-writing engines and the write ports (port B) of the even/odd VRAM banks. It accepts pixel writes from two requesters (A: renderer, B: secondary engine such as a blitter) over valid/ready handshakes. Each write is routed to a bank by pixel-address LSB, with per-bank round-robin arbitration. An optional built-in sequencer fills both banks with a constant value.

## Interface
- ADDR_W, 10, bank address width; pixel address is ADDR_W+1 bits.
- DATA_W, 8, pixel data width.

- clk  in  1  renderer clock domain; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A write request.
- a_ready  out  1  requester A accepted this cycle (transfer = valid & ready).
- a_addr  in  ADDR_W+1  pixel address; bit 0 = bank (0 even, 1 odd), bits [ADDR_W:1] = bank address.
- a_data  in  DATA_W  pixel value.
- b_valid, b_ready, b_addr, b_data: as A, for requester B.
- clear_start  in  1  single-cycle clear request.
- clear_value  in  DATA_W  fill value, sampled with clear_start.
- clear_busy  out  1  clear in progress.
- vram_even_we / vram_odd_we  out  1  bank write enable.
- vram_even_addr / vram_odd_addr  out  ADDR_W  bank write address.
- vram_even_d / vram_odd_d  out  DATA_W  bank write data.
- stall_count  out  16  saturating contention counter.

## Operation
- Requester rules: once valid is high, addr/data/valid are held until ready. a_ready/b_ready are combinational from valid, addr, arbiter state; requesters must not make valid depend on ready.
- States: IDLE, CLEAR, DONE. Ready is 0 unless state = IDLE.
- Per bank k in IDLE: candidates = requesters with valid and addr[0] = k. One candidate is granted. Two candidates: grant rr[k]; the other gets ready = 0.
- rr[k] is per bank and resets to A. After any grant in bank k, rr[k] points to the non-granted requester.
- A and B targeting different banks are both granted in the same cycle.
- Accepted write: on the next edge, the bank's we = 1, addr = pixel addr[ADDR_W:1], d = data. With no write, we = 0 and addr/d hold their last values.
- stall_count: +1 on each cycle in IDLE where a requester is valid and not ready. Saturates at 0xFFFF. Cleared only by reset.
- Clear (macro enabled): clear_start in IDLE latches clear_value and the state goes to CLEAR.
  - CLEAR: an ADDR_W-bit counter runs 0..2^ADDR_W-1. Each cycle it drives both banks: we = 1, addr = counter, d = latched value.
  - After the last address, the state goes to DONE for 1 cycle, then IDLE.
  - clear_start in CLEAR or DONE is ignored.
- Simultaneous clear_start and requests in IDLE: the requests are still granted that cycle. Clear writes start afterwards, with no bank collision.
- Reset values: all we = 0, addr = 0, d = 0, clear_busy = 0, stall_count = 0, state IDLE, rr = A, counter = 0.
- rst_n asserted mid-clear: the clear is abandoned immediately and the outputs take their reset values asynchronously.

## Timing
- Write latency: transfer at edge T gives bank we/addr/d valid in cycle T+1.
- Throughput: up to 2 writes/cycle (one per bank); 1 write/cycle per requester.
- Clear, with clear_start sampled at edge T:
  - CLEAR spans T+1..T+2^ADDR_W. First write (addr 0) on the outputs at T+2.
  - DONE at T+2^ADDR_W+1, carrying the last write (addr 2^ADDR_W-1).
  - IDLE at T+2^ADDR_W+2.
  - clear_busy = (state != IDLE): high T+1..T+2^ADDR_W+1.
  - Default (ADDR_W = 10): 1024 writes per bank; busy for 1025 cycles.
- Counter arithmetic wraps ADDR_W bits. Termination is on the all-ones value, not on overflow.

## Configuration
- VRAM_WR_ARB_CLEAR_EN defined: clear sequencer, CLEAR/DONE states and counter are built.
- Undefined: clear_start and clear_value are ignored, clear_busy is tied to 0, and the state is permanently IDLE. Arbitration is unchanged.

## Test plan
- A writes addr 0x003 data 0x5A (no B activity) -> a_ready = 1 the same cycle; next cycle vram_odd_we = 1, vram_odd_addr = 0x001, vram_odd_d = 0x5A; vram_even_we = 0.
- A at 0x004 and B at 0x007, same cycle -> both ready; next cycle even addr 0x002 and odd addr 0x003 are written simultaneously.
- A and B both hold valid on even bank addresses for 4 cycles after reset -> grants A, B, A, B; stall_count = 4.
- clear_start with clear_value 0xFF (macro on) -> both banks write 0xFF to addresses 0..1023 over 1024 consecutive cycles. clear_busy is high for 1025 cycles and ready is 0 throughout. A pending A request completes 1 cycle after clear_busy falls.
- rst_n pulsed low during a clear at counter 0x100 -> we = 0 immediately, clear_busy = 0, stall_count = 0. The next request is served normally with rr = A.
- Macro off, clear_start pulsed -> clear_busy stays 0, no extra writes, and requests are accepted the same cycle.
